// File: rtl/trex_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the T-rex register file (slave).
interface trex_axil_regs_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/trex_axil_regs.sv
// T-rex game control register file: four 32-bit AXI4-Lite R/W registers with write pulses.
module trex_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_NUM_REGS         = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  trex_axil_regs_if.slave               s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
  output logic [C_NUM_REGS-1:0]         reg_wr_pulse_o
);
  localparam int unsigned Dw = C_S_AXI_DATA_WIDTH;
  localparam int unsigned Sw = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned Iw = C_S_AXI_ADDR_WIDTH - 2;

  logic [C_NUM_REGS-1:0][Dw-1:0] regs_q, regs_d;
  logic                 aw_held_q, aw_held_d;
  logic [Iw-1:0]        aw_idx_q, aw_idx_d;
  logic                 w_held_q, w_held_d;
  logic [Dw-1:0]        w_data_q, w_data_d;
  logic [Sw-1:0]        w_strb_q, w_strb_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic [Dw-1:0]        rdata_q, rdata_d;
  logic [C_NUM_REGS-1:0] pulse_q, pulse_d;
  logic                 aw_hs, w_hs, ar_hs, commit;

  // Protection bits and the byte offset within a register carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Next-state: hold AW/W until both are present, commit, then respond; reads run independently.
  always_comb begin
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    pulse_d   = '0;

    aw_hs = s_axi.S_AXI_AWVALID & awready_q;
    w_hs  = s_axi.S_AXI_WVALID & wready_q;
    ar_hs = s_axi.S_AXI_ARVALID & arready_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi.S_AXI_WDATA;
      w_strb_d = s_axi.S_AXI_WSTRB;
    end

    // Same-cycle handshakes count as held, so the _d copies are the effective latched values.
    commit = aw_held_d & w_held_d;
    if (commit) begin
      for (int unsigned b = 0; b < Sw; b++) begin
        if (w_strb_d[b]) regs_d[aw_idx_d][8*b +: 8] = w_data_d[8*b +: 8];
      end
      pulse_d[aw_idx_d] = 1'b1;
      bvalid_d          = 1'b1;
      aw_held_d         = 1'b0;
      w_held_d          = 1'b0;
    end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Read samples regs_q, so a colliding commit is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
    arready_d = ~rvalid_d;
  end

  // State registers; reset discards any half-complete transaction.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      pulse_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign reg0_o         = regs_q[0];
  assign reg1_o         = regs_q[1];
  assign reg2_o         = regs_q[2];
  assign reg3_o         = regs_q[3];
  assign reg_wr_pulse_o = pulse_q;
endmodule
